// File: rtl/bridge_arbiter.sv
// bridge_arbiter: round-robin two-master arbiter with bounded lock, sharing one Bridge port.
// Ports: clk/reset; mN_req/lock/address/write_data/write_size/read_size from masters;
// mN_grant/ack/read_data/error back to masters; bridge_* payload out, bridge_read_data/accepted in.
module bridge_arbiter #(
  parameter int LOCK_MAX       = 4,
  parameter int LOCK_CNT_WIDTH = 3,
  parameter int FIRST_MASTER   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [2:0]  m0_write_size,
  input  logic [2:0]  m0_read_size,
  output logic        m0_grant,
  output logic        m0_ack,
  output logic [31:0] m0_read_data,
  output logic        m0_error,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [2:0]  m1_write_size,
  input  logic [2:0]  m1_read_size,
  output logic        m1_grant,
  output logic        m1_ack,
  output logic [31:0] m1_read_data,
  output logic        m1_error,
  output logic [31:0] bridge_address,
  output logic [31:0] bridge_write_data,
  output logic [2:0]  bridge_write_size,
  output logic [2:0]  bridge_read_size,
  input  logic [31:0] bridge_read_data,
  input  logic        bridge_accepted
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  localparam logic FM = 1'(FIRST_MASTER);
  localparam logic [LOCK_CNT_WIDTH-1:0] CNT_TOP = LOCK_CNT_WIDTH'(LOCK_MAX - 1);
  state_t state, nxt_state;
  logic owner, nxt_owner, last_owner;
  logic [LOCK_CNT_WIDTH-1:0] lock_cnt;
  logic owner_req, other_req, owner_lock, cont, done, any_req;
  always_comb begin
    owner_req  = owner ? m1_req : m0_req;
    other_req  = owner ? m0_req : m1_req;
    owner_lock = owner ? m1_lock : m0_lock;
    // lock only yields to a waiting master once the burst budget is spent
    cont       = state == ACK && owner_req && owner_lock && (!other_req || lock_cnt < CNT_TOP);
    done       = state == XFER && owner_req;
    any_req    = m0_req | m1_req;
    nxt_owner  = (state != XFER && !cont && any_req) ? ((m0_req && m1_req) ? ~last_owner : m1_req) : owner;
    nxt_state  = state == XFER ? (owner_req ? ACK : IDLE) : ((cont || any_req) ? XFER : IDLE);
  end
  assign bridge_address    = owner ? m1_address : m0_address;
  assign bridge_write_data = owner ? m1_write_data : m0_write_data;
  // sizes gated so an abandoned or reset-interrupted transfer never touches a device
  assign bridge_write_size = (done && !reset) ? (owner ? m1_write_size : m0_write_size) : 3'd0;
  assign bridge_read_size  = (done && !reset) ? (owner ? m1_read_size : m0_read_size) : 3'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= FM;
      last_owner   <= ~FM;
      lock_cnt     <= '0;
      m0_grant     <= 1'b0;
      m1_grant     <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_error     <= 1'b0;
      m1_error     <= 1'b0;
      m0_read_data <= '0;
      m1_read_data <= '0;
    end else begin
      state      <= nxt_state;
      owner      <= nxt_owner;
      m0_grant   <= nxt_state == XFER && !nxt_owner;
      m1_grant   <= nxt_state == XFER && nxt_owner;
      m0_ack     <= done && !owner;
      m1_ack     <= done && owner;
      m0_error   <= done && !owner && !bridge_accepted;
      m1_error   <= done && owner && !bridge_accepted;
      lock_cnt   <= cont ? ((lock_cnt == CNT_TOP) ? lock_cnt : lock_cnt + 1'b1) : (done ? lock_cnt : '0);
      if (done) last_owner <= owner;
      if (done && !owner) m0_read_data <= bridge_read_data;
      if (done && owner) m1_read_data <= bridge_read_data;
    end
  end
endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter: directed bench with a cycle model of the arbiter and a small timer-register bridge.
module tb_bridge_arbiter;
  localparam int LOCK_MAX = 4;
  logic clk = 0, reset = 1;
  logic m0_req = 0, m0_lock = 0, m1_req = 0, m1_lock = 0;
  logic [31:0] m0_address = 0, m0_write_data = 0, m1_address = 0, m1_write_data = 0;
  logic [2:0] m0_write_size = 0, m0_read_size = 0, m1_write_size = 0, m1_read_size = 0;
  logic m0_grant, m0_ack, m0_error, m1_grant, m1_ack, m1_error;
  logic [31:0] m0_read_data, m1_read_data;
  logic [31:0] bridge_address, bridge_write_data, bridge_read_data;
  logic [2:0] bridge_write_size, bridge_read_size;
  logic bridge_accepted;
  logic [31:0] tr [2][4];
  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  bridge_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_write_size(m0_write_size), .m0_read_size(m0_read_size), .m0_grant(m0_grant), .m0_ack(m0_ack),
    .m0_read_data(m0_read_data), .m0_error(m0_error),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_write_size(m1_write_size), .m1_read_size(m1_read_size), .m1_grant(m1_grant), .m1_ack(m1_ack),
    .m1_read_data(m1_read_data), .m1_error(m1_error),
    .bridge_address(bridge_address), .bridge_write_data(bridge_write_data),
    .bridge_write_size(bridge_write_size), .bridge_read_size(bridge_read_size),
    .bridge_read_data(bridge_read_data), .bridge_accepted(bridge_accepted)
  );
  // timer0 at 0x7F00..0x7F0F, timer1 at 0x7F10..0x7F1F, word registers
  assign bridge_accepted  = bridge_address[31:5] == 27'h3F8;
  assign bridge_read_data = bridge_accepted ? tr[bridge_address[4]][bridge_address[3:2]] : 32'h0;
  always @(posedge clk)
    if (bridge_write_size != 0 && bridge_accepted) tr[bridge_address[4]][bridge_address[3:2]] <= bridge_write_data;
  function automatic logic mhit(input logic [31:0] a);
    return a[31:5] == 27'h3F8;
  endfunction
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mhit(a) ? tr[a[4]][a[3:2]] : 32'h0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle, 1 transfer, 2 acknowledge
  int ph = 0, cnt = 0;
  bit own = 0, last = 1, arb;
  bit [1:0] eg = 0, ea = 0, ee = 0;
  bit r [2], lk [2];
  logic [31:0] ad [2];
  logic [31:0] erd [2];
  always @(posedge clk) begin
    r[0] = m0_req; r[1] = m1_req; lk[0] = m0_lock; lk[1] = m1_lock; ad[0] = m0_address; ad[1] = m1_address;
    if (reset) begin
      ph = 0; own = 0; last = 1; cnt = 0; eg = 0; ea = 0; ee = 0; erd[0] = 0; erd[1] = 0;
    end else begin
      ea = 0; ee = 0; arb = (ph == 0);
      if (ph == 1) begin
        if (r[own]) begin
          ea[own] = 1; ee[own] = !mhit(ad[own]); erd[own] = mrd(ad[own]); last = own; ph = 2;
        end else begin
          ph = 0; cnt = 0;
        end
      end else if (ph == 2) begin
        if (r[own] && lk[own] && (!r[!own] || cnt < LOCK_MAX - 1)) begin
          ph = 1; cnt = (cnt < LOCK_MAX - 1) ? cnt + 1 : cnt;
        end else begin
          cnt = 0; arb = 1;
        end
      end
      if (arb) begin
        ph = (r[0] || r[1]) ? 1 : 0;
        if (r[0] || r[1]) own = (r[0] && r[1]) ? !last : r[1];
      end
      eg[0] = ph == 1 && !own;
      eg[1] = ph == 1 && own;
    end
  end
  always @(negedge clk) if (chk_on) begin
    logic live;
    live = !reset && ph == 1 && (own ? m1_req : m0_req);
    chk("m0_grant", m0_grant, eg[0]);
    chk("m1_grant", m1_grant, eg[1]);
    chk("m0_ack", m0_ack, ea[0]);
    chk("m1_ack", m1_ack, ea[1]);
    chk("m0_error", m0_error, ee[0]);
    chk("m1_error", m1_error, ee[1]);
    chk("m0_read_data", m0_read_data, erd[0]);
    chk("m1_read_data", m1_read_data, erd[1]);
    chk("bridge_write_size", bridge_write_size, live ? (own ? m1_write_size : m0_write_size) : 3'd0);
    chk("bridge_read_size", bridge_read_size, live ? (own ? m1_read_size : m0_read_size) : 3'd0);
    if (eg != 0) begin
      chk("bridge_address", bridge_address, own ? m1_address : m0_address);
      chk("bridge_write_data", bridge_write_data, own ? m1_write_data : m0_write_data);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic setm(input int m, input logic rq, input logic lock, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] ws, input logic [2:0] rs);
    if (m == 0) begin
      m0_req = rq; m0_lock = lock; m0_address = a; m0_write_data = wd; m0_write_size = ws; m0_read_size = rs;
    end else begin
      m1_req = rq; m1_lock = lock; m1_address = a; m1_write_data = wd; m1_write_size = ws; m1_read_size = rs;
    end
  endtask
  task automatic do_xfer(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ws,
                         input logic [2:0] rs, output logic e, output logic [31:0] d);
    int k = 0;
    setm(m, 1, 0, a, wd, ws, rs);
    do begin
      step();
      k++;
    end while (!(m == 1 ? m1_ack : m0_ack) && k < 10);
    chk("xfer_ack", m == 1 ? m1_ack : m0_ack, 1);
    e = m == 1 ? m1_error : m0_error;
    d = m == 1 ? m1_read_data : m0_read_data;
    setm(m, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic e;
    logic [31:0] d;
    int seq [$];
    int n1;
    tr[0][0] = 0; tr[0][1] = 32'h0000_0ABC; tr[0][2] = 0; tr[0][3] = 0;
    tr[1][0] = 32'h11; tr[1][1] = 32'h22; tr[1][2] = 32'h33; tr[1][3] = 32'h44;
    step(2);
    chk_on = 1;
    chk("rst_flags", {26'd0, m0_grant, m1_grant, m0_ack, m1_ack, m0_error, m1_error}, 0);
    chk("rst_rd0", m0_read_data, 0);
    chk("rst_rd1", m1_read_data, 0);
    reset = 0;
    setm(0, 1, 0, 32'h7F00, 32'h5, 3'd2, 3'd0);
    step();
    chk("w_grant", m0_grant, 1);
    chk("w_ws", bridge_write_size, 2);
    step();
    chk("w_ack", m0_ack, 1);
    chk("w_ws_ack", bridge_write_size, 0);
    setm(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("w_ctrl", tr[0][0], 5);
    do_xfer(0, 32'h7F00, 0, 3'd0, 3'd2, e, d);
    chk("rb_ctrl", d, 5);
    do_xfer(0, 32'h3000, 0, 3'd0, 3'd2, e, d);
    chk("unmapped_err", e, 1);
    do_xfer(0, 32'h7F04, 0, 3'd0, 3'd2, e, d);
    chk("preset_err", e, 0);
    chk("preset_data", d, 32'h0000_0ABC);
    do_xfer(1, 32'h7F00, 0, 3'd0, 3'd0, e, d);
    chk("nosize_err", e, 0);
    reset = 1;
    step(2);
    reset = 0;
    setm(0, 1, 0, 32'h7F04, 0, 3'd0, 3'd2);
    setm(1, 1, 0, 32'h7F14, 0, 3'd0, 3'd2);
    for (int i = 0; i < 32; i++) begin
      step();
      chk("one_grant", m0_grant & m1_grant, 0);
      if (m0_grant) seq.push_back(0);
      if (m1_grant) seq.push_back(1);
    end
    setm(0, 0, 0, 0, 0, 0, 0);
    setm(1, 0, 0, 0, 0, 0, 0);
    chk("alt_len", seq.size(), 16);
    foreach (seq[i]) chk("alt_order", seq[i], i % 2);
    step();
    setm(1, 1, 1, 32'h7F14, 0, 3'd0, 3'd2);
    step();
    chk("lock_first", m1_grant, 1);
    setm(0, 1, 0, 32'h7F04, 0, 3'd0, 3'd2);
    n1 = 1;
    for (int k = 0; k < 20 && !m0_grant; k++) begin
      step();
      if (m1_grant) n1++;
    end
    chk("lock_m1_count", n1, 4);
    chk("lock_m0_grant", m0_grant, 1);
    setm(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("lock_m0_ack", m0_ack, 1);
    setm(0, 0, 0, 0, 0, 0, 0);
    step();
    setm(1, 1, 1, 32'h7F14, 0, 3'd0, 3'd2);
    step(20);
    chk("sat_m1_ack", m1_ack, 1);
    setm(0, 1, 0, 32'h7F04, 0, 3'd0, 3'd2);
    step();
    chk("sat_m0_grant", m0_grant, 1);
    setm(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("sat_m0_ack", m0_ack, 1);
    setm(0, 0, 0, 0, 0, 0, 0);
    step();
    setm(1, 1, 0, 32'h7F10, 32'h99, 3'd2, 3'd0);
    step();
    chk("rx_grant", m1_grant, 1);
    reset = 1;
    #1 chk("rx_ws", bridge_write_size, 0);
    step();
    setm(1, 0, 0, 0, 0, 0, 0);
    reset = 0;
    chk("rx_noack", m1_ack, 0);
    step();
    chk("rx_timer1", tr[1][0], 32'h11);
    chk("rx_idle", {m0_grant, m1_grant, m1_ack}, 0);
    setm(0, 1, 0, 32'h7F04, 0, 3'd0, 3'd2);
    step();
    chk("drop_grant", m0_grant, 1);
    setm(0, 0, 0, 0, 0, 0, 0);
    #1 chk("drop_rs", bridge_read_size, 0);
    step();
    chk("drop_noack", m0_ack, 0);
    chk("drop_idle", m0_grant, 0);
    step();
    chk("drop_still_idle", {m0_grant, m0_ack}, 0);
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
